output_interface_mc: RTL and testbench

//   Multi-channel successor of the single-channel C->D output stage. Accepts

---
 rtl/oif_pkg.sv | 41 ++++
 rtl/oif_chan_fifo.sv | 66 ++++++
 rtl/output_interface_mc.sv | 115 +++++++++++
 tb/tb_output_interface_mc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oif_pkg.sv
// Shared types and helpers for the multi-channel C->D output stage.
// Optional feature macro: OIF_CHAN_TAG_EN (adds the c2d_pkt_chan source-lane tag).
package oif_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_BUF_AW = 3;
  localparam int DEF_INFO_W = 20;
  localparam int DEF_ID_W   = 3;
  localparam int DEF_DATA_W = 512;

  // Upper bound on lanes understood by rr_next.
  localparam int MAX_CH = 32;

  // Buffered entry, MSB to LSB: info, id, so, payload.
  typedef struct packed {
    logic [DEF_INFO_W-1:0] info;
    logic [DEF_ID_W-1:0]   id;
    logic                  so;
    logic [DEF_DATA_W-1:0] payload;
  } oif_entry_t;

  localparam int ENTRY_W     = $bits(oif_entry_t);
  localparam int OFF_PAYLOAD = 0;
  localparam int OFF_SO      = OFF_PAYLOAD + DEF_DATA_W;
  localparam int OFF_ID      = OFF_SO + 1;
  localparam int OFF_INFO    = OFF_ID + DEF_ID_W;

  // First requesting lane after ptr (wrapping mod n). Returns ptr when
  // nothing requests; callers gate on req != 0.
  function automatic int rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    int res;
    int idx;
    res = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (req[idx[$clog2(MAX_CH)-1:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/oif_chan_fifo.sv
// Per-lane first-word-fall-through FIFO: rd_data always shows the head
// entry while !empty. Writes when full and reads when empty are dropped.
module oif_chan_fifo
  import oif_pkg::*;
#(
  parameter int WIDTH  = ENTRY_W,
  parameter int BUF_AW = DEF_BUF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int CNT_W = BUF_AW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally mod depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/output_interface_mc.sv
// Multi-channel C->D output stage: NUM_CH FWFT lane buffers drained by a
// round-robin arbiter into one registered valid/ready port.
// Handshake: a packet moves to D on a clock edge where c2d_pkt_vld and
// d2c_pkt_rdy are both high; while vld && !rdy every c2d_* output holds.
// Optional feature macro: OIF_CHAN_TAG_EN adds c2d_pkt_chan (source lane).
module output_interface_mc
  import oif_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int INFO_W = DEF_INFO_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUF_AW = DEF_BUF_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          wb_valid,
  input  logic [NUM_CH*INFO_W-1:0]   wb_info,
  input  logic [NUM_CH*ID_W-1:0]     wb_id,
  input  logic [NUM_CH-1:0]          wb_so,
  input  logic [NUM_CH*DATA_W-1:0]   wb_data,
  output logic [NUM_CH-1:0]          output_busy,
  output logic                       c2d_pkt_vld,
  output logic [INFO_W-1:0]          c2d_pkt_lkp_rslt,
  output logic [ID_W-1:0]            c2d_pkt_odr_id,
  output logic                       c2d_pkt_so,
  output logic [DATA_W-1:0]          c2d_pkt_payload,
`ifdef OIF_CHAN_TAG_EN
  output logic [$clog2(NUM_CH)-1:0]  c2d_pkt_chan,
`endif
  input  logic                       d2c_pkt_rdy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ENT_W = INFO_W + ID_W + 1 + DATA_W;

  logic [NUM_CH-1:0] full, empty, rd_en, req;
  logic [ENT_W-1:0]  head [NUM_CH];
  logic [ENT_W-1:0]  ent_q, ent_d;
  logic              vld_q, vld_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              load_en;
  int                grant;
  logic [CH_W-1:0]   grant_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    oif_chan_fifo #(.WIDTH(ENT_W), .BUF_AW(BUF_AW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .wr_en   (wb_valid[g]),
      .wr_data ({wb_info[g*INFO_W +: INFO_W], wb_id[g*ID_W +: ID_W],
                 wb_so[g], wb_data[g*DATA_W +: DATA_W]}),
      .rd_en   (rd_en[g]),
      .rd_data (head[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // Busy is pure buffer state, so it has no path from d2c_pkt_rdy.
  assign output_busy = full;

  // Arbitration and output-register next state: one pop per load.
  always_comb begin
    load_en   = !vld_q || d2c_pkt_rdy;
    req       = ~empty;
    grant     = rr_next(MAX_CH'(req), int'(ptr_q), NUM_CH);
    grant_idx = CH_W'(grant);
    rd_en     = '0;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    ent_d     = ent_q;
    if (load_en) begin
      vld_d = 1'b0;
      if (req != '0) begin
        rd_en[grant_idx] = 1'b1;
        ptr_d            = grant_idx;
        vld_d            = 1'b1;
        ent_d            = head[grant_idx];
      end
    end
  end

  // Output register and round-robin pointer (lane 0 wins first after reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      ent_q <= '0;
      ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef OIF_CHAN_TAG_EN
  logic [CH_W-1:0] chan_q;

  // Source-lane tag travels with the payload it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chan_q <= '0;
    else if (load_en && (req != '0)) chan_q <= grant_idx;
  end

  assign c2d_pkt_chan = chan_q;
`endif

  assign c2d_pkt_vld      = vld_q;
  assign c2d_pkt_lkp_rslt = ent_q[ENT_W-1 -: INFO_W];
  assign c2d_pkt_odr_id   = ent_q[DATA_W+1 +: ID_W];
  assign c2d_pkt_so       = ent_q[DATA_W];
  assign c2d_pkt_payload  = ent_q[DATA_W-1:0];

endmodule

// File: tb/tb_output_interface_mc.sv
// Bench for output_interface_mc: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_output_interface_mc;

  localparam int NUM_CH = 4;
  localparam int INFO_W = 20;
  localparam int ID_W   = 3;
  localparam int DATA_W = 512;
  localparam int BUF_AW = 3;
  localparam int DEPTH  = 1 << BUF_AW;
  localparam int ENT_W  = INFO_W + ID_W + 1 + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH-1:0]        wb_valid = '0;
  logic [NUM_CH*INFO_W-1:0] wb_info = '0;
  logic [NUM_CH*ID_W-1:0]   wb_id = '0;
  logic [NUM_CH-1:0]        wb_so = '0;
  logic [NUM_CH*DATA_W-1:0] wb_data = '0;
  logic [NUM_CH-1:0]        output_busy;
  logic                     c2d_pkt_vld;
  logic [INFO_W-1:0]        c2d_pkt_lkp_rslt;
  logic [ID_W-1:0]          c2d_pkt_odr_id;
  logic                     c2d_pkt_so;
  logic [DATA_W-1:0]        c2d_pkt_payload;
  logic                     d2c_pkt_rdy = 1'b0;
`ifdef OIF_CHAN_TAG_EN
  logic [1:0]               c2d_pkt_chan;
`endif

  output_interface_mc #(.NUM_CH(NUM_CH), .INFO_W(INFO_W), .ID_W(ID_W),
                        .DATA_W(DATA_W), .BUF_AW(BUF_AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid         (wb_valid),
    .wb_info          (wb_info),
    .wb_id            (wb_id),
    .wb_so            (wb_so),
    .wb_data          (wb_data),
    .output_busy      (output_busy),
    .c2d_pkt_vld      (c2d_pkt_vld),
    .c2d_pkt_lkp_rslt (c2d_pkt_lkp_rslt),
    .c2d_pkt_odr_id   (c2d_pkt_odr_id),
    .c2d_pkt_so       (c2d_pkt_so),
    .c2d_pkt_payload  (c2d_pkt_payload),
`ifdef OIF_CHAN_TAG_EN
    .c2d_pkt_chan     (c2d_pkt_chan),
`endif
    .d2c_pkt_rdy      (d2c_pkt_rdy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q[i] holds what lane i's buffer must contain; m_* is the packet that
  // must be on the output port.
  logic [ENT_W-1:0] exp_q [NUM_CH][$];
  logic [ENT_W-1:0] m_ent;
  logic             m_vld = 1'b0;
  int               m_lane = 0;
  int               m_ptr = NUM_CH - 1;
  int               acc_m = 0;      // packets the model accepted
  int               delivered = 0;  // handshakes seen on the DUT port

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    m_vld  = 1'b0;
    m_ent  = '0;
    m_lane = 0;
    m_ptr  = NUM_CH - 1;
  endtask

  always @(posedge clk) begin
    logic [NUM_CH-1:0] busy_m;
    logic [NUM_CH-1:0] busy_now;
    logic              p_vld, p_rdy, found;
    logic [ENT_W-1:0]  p_ent;
    int                idx;
    p_vld = c2d_pkt_vld;
    p_rdy = d2c_pkt_rdy;
    p_ent = {c2d_pkt_lkp_rslt, c2d_pkt_odr_id, c2d_pkt_so, c2d_pkt_payload};
    if (!rst) begin
      model_reset();
    end else begin
      if (p_vld && p_rdy) delivered++;
      for (int i = 0; i < NUM_CH; i++) busy_m[i] = (exp_q[i].size() == DEPTH);
      if (!m_vld || p_rdy) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
          idx = (m_ptr + k) % NUM_CH;
          if (!found && exp_q[idx].size() > 0) begin
            found  = 1'b1;
            m_ent  = exp_q[idx].pop_front();
            m_lane = idx;
            m_ptr  = idx;
          end
        end
        m_vld = found;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wb_valid[i] && !busy_m[i]) begin
          exp_q[i].push_back({wb_info[i*INFO_W +: INFO_W], wb_id[i*ID_W +: ID_W],
                              wb_so[i], wb_data[i*DATA_W +: DATA_W]});
          acc_m++;
        end
      end
    end
    #1;
    for (int i = 0; i < NUM_CH; i++) busy_now[i] = (exp_q[i].size() == DEPTH);
    chk("vld", DATA_W'(c2d_pkt_vld), DATA_W'(m_vld));
    chk("busy", DATA_W'(output_busy), DATA_W'(busy_now));
    if (!rst) begin
      chk("rst_info", DATA_W'(c2d_pkt_lkp_rslt), '0);
      chk("rst_id", DATA_W'(c2d_pkt_odr_id), '0);
      chk("rst_so", DATA_W'(c2d_pkt_so), '0);
      chk("rst_payload", c2d_pkt_payload, '0);
    end else if (m_vld) begin
      chk("info", DATA_W'(c2d_pkt_lkp_rslt), DATA_W'(m_ent[ENT_W-1 -: INFO_W]));
      chk("id", DATA_W'(c2d_pkt_odr_id), DATA_W'(m_ent[DATA_W+1 +: ID_W]));
      chk("so", DATA_W'(c2d_pkt_so), DATA_W'(m_ent[DATA_W]));
      chk("payload", c2d_pkt_payload, m_ent[DATA_W-1:0]);
`ifdef OIF_CHAN_TAG_EN
      chk("chan", DATA_W'(c2d_pkt_chan), DATA_W'(m_lane));
`endif
      if (p_vld && !p_rdy)
        chk("hold", DATA_W'({c2d_pkt_lkp_rslt, c2d_pkt_odr_id, c2d_pkt_so, c2d_pkt_payload} ^ p_ent), '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_lane(input int lane, input int seq);
    wb_valid[lane]                   = 1'b1;
    wb_info[lane*INFO_W +: INFO_W]   = {2'(lane), 18'(seq)};
    wb_id[lane*ID_W +: ID_W]         = 3'(seq);
    wb_so[lane]                      = (seq % 3 == 0);
    wb_data[lane*DATA_W +: DATA_W]   = {16{8'(lane), 24'(seq)}};
  endtask

  task automatic next_cycle();
    @(negedge clk);
    wb_valid = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wb_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int seq_l [NUM_CH];
  int acc_d, del0, acc0, n_out, cyc, last_seq;

  initial begin
    // 1: reset, no traffic
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d2c_pkt_rdy = 1'b1;
    @(negedge clk);
    chk("t1_vld", DATA_W'(c2d_pkt_vld), '0);
    chk("t1_busy", DATA_W'(output_busy), '0);
    chk("t1_payload", c2d_pkt_payload, '0);

    // 2: single packet on lane 2, latency one edge after the write
    @(negedge clk);
    set_lane(2, 7);
    wb_id[2*ID_W +: ID_W]         = 3'd5;
    wb_so[2]                      = 1'b1;
    wb_info[2*INFO_W +: INFO_W]   = 20'h12345;
    wb_data[2*DATA_W +: DATA_W]   = {64{8'hA5}};
    next_cycle();
    chk("t2_vld_k", DATA_W'(c2d_pkt_vld), '0);
    next_cycle();
    chk("t2_vld_k1", DATA_W'(c2d_pkt_vld), 1);
    chk("t2_id", DATA_W'(c2d_pkt_odr_id), 5);
    chk("t2_so", DATA_W'(c2d_pkt_so), 1);
    chk("t2_info", DATA_W'(c2d_pkt_lkp_rslt), 'h12345);
    chk("t2_payload", c2d_pkt_payload, {64{8'hA5}});
    next_cycle();
    chk("t2_vld_k2", DATA_W'(c2d_pkt_vld), '0);

    // 3: all lanes at once, round-robin order 0..3, twice
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) set_lane(i, 20 + r);
      next_cycle();
      for (int j = 0; j < NUM_CH; j++) begin
        next_cycle();
        chk("t3_vld", DATA_W'(c2d_pkt_vld), 1);
        chk("t3_lane", DATA_W'(c2d_pkt_lkp_rslt[19:18]), DATA_W'(j));
      end
      repeat (3) next_cycle();
    end

    // 4: fill lane 1 with rdy low; busy after the 9th write, 10th dropped
    d2c_pkt_rdy = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      wb_valid = '0;
      if (j == 8) chk("t4_busy_8", DATA_W'(output_busy[1]), 0);
      if (j == 9) chk("t4_busy_9", DATA_W'(output_busy[1]), 1);
      set_lane(1, 100 + j);
    end
    next_cycle();
    d2c_pkt_rdy = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      if (c2d_pkt_vld) begin
        chk("t4_order", DATA_W'(c2d_pkt_lkp_rslt[17:0]), DATA_W'(100 + n_out));
        n_out++;
      end
      next_cycle();
    end
    chk("t4_count", DATA_W'(n_out), 9);

    // 5: random ready and random lane traffic, 1000 packets
    del0  = delivered;
    acc0  = acc_m;
    acc_d = 0;
    cyc   = 0;
    for (int i = 0; i < NUM_CH; i++) seq_l[i] = 1000;
    while (acc_d < 1000 && cyc < 6000) begin
      @(negedge clk);
      wb_valid = '0;
      d2c_pkt_rdy = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_CH; i++) begin
        if (!output_busy[i] && $urandom_range(0, 2) != 0 && acc_d < 1000) begin
          set_lane(i, seq_l[i]);
          seq_l[i]++;
          acc_d++;
        end
      end
      cyc++;
    end
    chk("t5_budget", DATA_W'(acc_d >= 1000), 1);
    next_cycle();
    d2c_pkt_rdy = 1'b1;
    repeat (40) next_cycle();
    chk("t5_accepted", DATA_W'(acc_m - acc0), DATA_W'(acc_d));
    chk("t5_delivered", DATA_W'(delivered - del0), DATA_W'(acc_d));

    // 6: async reset with packets in flight; lane 0 wins first afterwards
    d2c_pkt_rdy = 1'b0;
    @(negedge clk);
    for (int i = 1; i < NUM_CH; i++) set_lane(i, 300 + i);
    next_cycle();
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_vld", DATA_W'(c2d_pkt_vld), '0);
    chk("t6_busy", DATA_W'(output_busy), '0);
    chk("t6_payload", c2d_pkt_payload, '0);
    @(negedge clk);
    rst = 1'b1;
    d2c_pkt_rdy = 1'b1;
    @(negedge clk);
    set_lane(3, 400);
    set_lane(0, 401);
    next_cycle();
    next_cycle();
    chk("t6_first_lane", DATA_W'(c2d_pkt_lkp_rslt[19:18]), 0);
    last_seq = int'(c2d_pkt_lkp_rslt[17:0]);
    chk("t6_first_seq", DATA_W'(last_seq), 401);
    next_cycle();
    chk("t6_second_lane", DATA_W'(c2d_pkt_lkp_rslt[19:18]), 3);
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
